// File: rtl/nfc_link_ctrl.sv
// Half-duplex NFC link controller: round-robin arbitration, Manchester framing, guard gap.
// Far-end capture is built only when NFC_LINK_CAPTURE_EN is defined.
module nfc_link_ctrl #(
  parameter int unsigned BIT_CYCLES   = 128,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned GUARD_CYCLES = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tx_req,
  input  logic [FRAME_BITS-1:0]              tx_data,
  input  logic [$clog2(FRAME_BITS+1)-1:0]    tx_len,
  input  logic                               rx_req,
  input  logic [FRAME_BITS-1:0]              rx_data,
  input  logic [$clog2(FRAME_BITS+1)-1:0]    rx_len,
  input  logic                               tx_recv,
  input  logic                               rx_recv,
  output logic                               tx_send,
  output logic                               rx_send,
  output logic                               tx_ack,
  output logic                               rx_ack,
  output logic                               tx_done,
  output logic                               rx_done,
  output logic                               busy,
  output logic [FRAME_BITS-1:0]              cap_data,
  output logic                               cap_valid,
  output logic                               cap_match
);

  localparam int unsigned LW = $clog2(FRAME_BITS + 1);
  localparam int unsigned CW = $clog2(BIT_CYCLES);
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

  localparam logic [LW-1:0] LenMax    = LW'(FRAME_BITS);
  localparam logic [CW-1:0] CycHalf   = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] CycLast   = CW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GuardLast = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGuard} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic                  grant_rx_q, grant_rx_d;
  logic                  last_rx_q, last_rx_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [LW-1:0]         len_q, len_d;

  logic tx_send_q, tx_send_d, rx_send_q, rx_send_d;
  logic tx_ack_q, tx_ack_d, rx_ack_q, rx_ack_d;
  logic tx_done_q, tx_done_d, rx_done_q, rx_done_d;
  logic busy_q, busy_d;

  logic                  rx_sel;
  logic [LW-1:0]         len_sel;
  logic [FRAME_BITS-1:0] shifted;
  logic                  mod_d;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    gcnt_d     = gcnt_q;
    grant_rx_d = grant_rx_q;
    last_rx_d  = last_rx_q;
    data_d     = data_q;
    len_d      = len_q;
    tx_ack_d   = 1'b0;
    rx_ack_d   = 1'b0;
    tx_done_d  = 1'b0;
    rx_done_d  = 1'b0;

    // With both requesting, the side not served last time wins.
    rx_sel  = rx_req && (!tx_req || !last_rx_q);
    len_sel = rx_sel ? rx_len : tx_len;

    unique case (state_q)
      StIdle: begin
        if (tx_req || rx_req) begin
          state_d    = StSend;
          grant_rx_d = rx_sel;
          last_rx_d  = rx_sel;
          data_d     = rx_sel ? rx_data : tx_data;
          len_d      = (len_sel > LenMax) ? LenMax : len_sel;
          idx_d      = len_d - LW'(1);
          cyc_d      = '0;
          tx_ack_d   = !rx_sel;
          rx_ack_d   = rx_sel;
        end
      end
      StSend: begin
        if (len_q == '0 || (cyc_q == CycLast && idx_q == '0)) begin
          state_d   = StGuard;
          gcnt_d    = '0;
          cyc_d     = '0;
          tx_done_d = !grant_rx_q;
          rx_done_d = grant_rx_q;
        end else if (cyc_q == CycLast) begin
          cyc_d = '0;
          idx_d = idx_q - LW'(1);
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      StGuard: begin
        if (gcnt_q == GuardLast) begin
          state_d = StIdle;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are derived from next-state values so the registered drive lines up with state.
    shifted = data_d >> idx_d;
    mod_d   = 1'b0;
    if (state_d == StSend && len_d != '0) begin
      mod_d = (cyc_d < CycHalf) ? shifted[0] : ~shifted[0];
    end
    tx_send_d = mod_d & ~grant_rx_d;
    rx_send_d = mod_d & grant_rx_d;
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      idx_q      <= '0;
      gcnt_q     <= '0;
      grant_rx_q <= 1'b0;
      last_rx_q  <= 1'b1;
      data_q     <= '0;
      len_q      <= '0;
      tx_send_q  <= 1'b0;
      rx_send_q  <= 1'b0;
      tx_ack_q   <= 1'b0;
      rx_ack_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      gcnt_q     <= gcnt_d;
      grant_rx_q <= grant_rx_d;
      last_rx_q  <= last_rx_d;
      data_q     <= data_d;
      len_q      <= len_d;
      tx_send_q  <= tx_send_d;
      rx_send_q  <= rx_send_d;
      tx_ack_q   <= tx_ack_d;
      rx_ack_q   <= rx_ack_d;
      tx_done_q  <= tx_done_d;
      rx_done_q  <= rx_done_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_send = tx_send_q;
  assign rx_send = rx_send_q;
  assign tx_ack  = tx_ack_q;
  assign rx_ack  = rx_ack_q;
  assign tx_done = tx_done_q;
  assign rx_done = rx_done_q;
  assign busy    = busy_q;

`ifdef NFC_LINK_CAPTURE_EN
  localparam logic [CW-1:0] CycQuarter = CW'(BIT_CYCLES / 4);

  logic [FRAME_BITS-1:0] cap_q, cap_d, len_mask;
  logic                  cap_valid_q, cap_match_q, cap_match_d;
  logic                  far_bit, cap_start, frame_end;

  always_comb begin
    cap_d       = cap_q;
    cap_match_d = cap_match_q;
    cap_start   = (state_q == StIdle) && (tx_req || rx_req);
    frame_end   = tx_done_d | rx_done_d;
    far_bit     = grant_rx_q ? tx_recv : rx_recv;
    len_mask    = ~({FRAME_BITS{1'b1}} << len_q);
    if (cap_start) begin
      cap_d = '0;
    end else if (state_q == StSend && len_q != '0 && cyc_q == CycQuarter) begin
      // Sample a quarter bit in, safely inside the first Manchester half.
      cap_d = (cap_q << 1) | FRAME_BITS'(far_bit);
    end
    if (frame_end) begin
      cap_match_d = (cap_q == (data_q & len_mask));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_match_q <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      cap_valid_q <= frame_end;
      cap_match_q <= cap_match_d;
    end
  end

  assign cap_data  = cap_q;
  assign cap_valid = cap_valid_q;
  assign cap_match = cap_match_q;
`else
  logic unused_recv;
  assign unused_recv = tx_recv ^ rx_recv;
  assign cap_data    = '0;
  assign cap_valid   = 1'b0;
  assign cap_match   = 1'b0;
`endif

endmodule
